// File: rtl/keypad_scan_debounce_if.sv
// Keypad-side signal bundle: row sense in, column drive and decoded key events out.
interface keypad_scan_debounce_if;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport slave (
    input  key_row,
    output key_col,
    output key_valid,
    output key_code,
    output key_held
  );

  modport master (
    output key_row,
    input  key_col,
    input  key_valid,
    input  key_code,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 3x4 keypad scanner: rotates a one-hot column drive on a slow tick, debounces
// a single-row hit, and reports one key_valid pulse per accepted press.
module keypad_scan_debounce #(
  parameter int unsigned CLK_DIV  = 12499,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_scan_debounce_if.slave kp
);

  localparam int unsigned CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV);
  localparam logic [3:0]    DEB_N   = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_m, row_s;
  logic [CW-1:0] div_q;
  logic          tick;
  logic [2:0]    col_q, col_d, col_next;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    cnt_q, cnt_d, cnt_inc;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          single_key;

  function automatic logic [3:0] code_of(input logic [2:0] col, input logic [3:0] row);
    logic [3:0] c;
    c = '0;
    unique case (row)
      4'b0001: c = col[0] ? 4'd1  : col[1] ? 4'd2 : 4'd3;
      4'b0010: c = col[0] ? 4'd4  : col[1] ? 4'd5 : 4'd6;
      4'b0100: c = col[0] ? 4'd7  : col[1] ? 4'd8 : 4'd9;
      4'b1000: c = col[0] ? 4'd10 : col[1] ? 4'd0 : 4'd11;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Two-flop synchronizer on the asynchronous row sense lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= kp.key_row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (div_q == DIV_MAX) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick       = (div_q == DIV_MAX);
  assign col_next   = {col_q[1:0], col_q[2]};
  assign cnt_inc    = cnt_q + 4'd1;
  assign single_key = (row_s != '0) && ((row_s & (row_s - 4'd1)) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SCAN;
      col_q   <= 3'b001;
      cap_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  // The column register doubles as the captured column while a key is tracked
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    code_d  = code_q;
    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (single_key) begin
            cap_d   = row_s;
            cnt_d   = 4'd1;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == cap_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              state_d = ST_HELD;
              valid_d = 1'b1;
              code_d  = code_of(col_q, cap_q);
            end
          end else begin
            state_d = ST_SCAN;
            cap_d   = '0;
            cnt_d   = '0;
            col_d   = col_next;
          end
        end
        ST_HELD: begin
          if (row_s == '0) begin
            cnt_d   = 4'd1;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row_s == '0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              state_d = ST_SCAN;
              cnt_d   = '0;
              col_d   = col_next;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  assign kp.key_col   = col_q;
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: doc/keypad_scan_debounce.md
KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 Parameter CLK_DIV, default 12499, scan tick period minus one in clk cycles (tick every CLK_DIV+1 clks).
REQ-002 Parameter DEBOUNCE, default 4, range 2..15, consecutive ticks needed to accept a press or a release.
REQ-003 clk  input  1  system clock; the block has one clock and all state is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 key_row  input  4  keypad row sense; bit0 = top row (1/2/3), bit3 = bottom row (*/0/#); 1 = pressed.
REQ-006 key_col  output  3  one-hot column drive; 001 = col1 (1/4/7/*), 010 = col2 (2/5/8/0), 100 = col3 (3/6/9/#).
REQ-007 key_valid  output  1  one-clk pulse per accepted press.
REQ-008 key_code  output  4  code of last accepted key; 0-9 = digit, 10 = *, 11 = #; valid when key_valid=1, held until next accept.
REQ-009 key_held  output  1  high while an accepted key stays pressed (HELD state).

Function
REQ-010 Tick counter SHALL count 0..CLK_DIV, pulse internal tick for one clk when count==CLK_DIV, then wrap to 0; it runs in every state.
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE; all transitions and key_col changes occur only on tick cycles.
REQ-012 SCAN, tick, key_row==0000: key_col SHALL rotate 001->010->100->001.
REQ-013 SCAN, tick, key_row has exactly one bit set: capture key_col and key_row, debounce count=1, go DEBOUNCE, key_col frozen.
REQ-014 SCAN, tick, key_row has two or more bits set: treat as no key; key_col rotates as in REQ-012.
REQ-015 DEBOUNCE, tick, key_row==captured row: count+1; when count reaches DEBOUNCE, go HELD and assert key_valid in the next clk for exactly one cycle with key_code per REQ-016.
REQ-016 key_code map: (col1,row0..3)=1,4,7,10; (col2,row0..3)=2,5,8,0; (col3,row0..3)=3,6,9,11.
REQ-017 DEBOUNCE, tick, key_row!=captured row: discard capture, no key_valid, go SCAN, advance key_col one step.
REQ-018 HELD: key_held=1, key_col frozen; tick with key_row==0000 -> release count=1, go RELEASE; any other key_row -> stay HELD, no further key_valid.
REQ-019 RELEASE: key_held=1; tick with key_row==0000 -> count+1, at DEBOUNCE go SCAN, key_held=0, advance key_col; tick with key_row!=0000 -> back to HELD, count cleared.
REQ-020 Exactly one key_valid per press regardless of hold duration; a bounce shorter than DEBOUNCE ticks during RELEASE SHALL NOT produce a second pulse.
REQ-021 Press-to-accept latency: key_valid rises 1 clk after the tick on which the DEBOUNCE-th consecutive matching sample is taken (first sample = capture tick).
REQ-022 Debounce and release counters SHALL be 4 bits, saturating logic not required since they never exceed DEBOUNCE.
REQ-023 key_row is sampled through a two-flop synchronizer; all decisions use the synchronized value (adds 2 clk input latency).

Reset
REQ-024 rst=0 asynchronously SHALL force: state SCAN, key_col=001, key_valid=0, key_code=0, key_held=0, tick counter 0, debounce/release counters 0, synchronizer flops 0.
REQ-025 rst asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort with no key_valid; after rst=1 scanning restarts at col1 and a still-pressed key is re-debounced from count 1.

Verification (CLK_DIV=3, DEBOUNCE=4)
REQ-026 Idle, key_row=0000 for 24 clks -> key_col cycles 001,010,100 changing every 4 clks, key_valid never high.
REQ-027 Press key 5 (row bit1 when key_col=010) held 40 clks -> one key_valid pulse, key_code=5, key_held=1 until release debounced.
REQ-028 Press # (row bit3 on col 100) for only 2 ticks then release -> no key_valid, scan resumes at 001.
REQ-029 Key 7 accepted, then during RELEASE row toggles 0000/0100 every tick for 6 ticks -> single key_valid total, key_held stays 1.
REQ-030 row=0011 on col 001 -> treated as no key, key_col advances to 010, no key_valid.
REQ-031 Key 0 in DEBOUNCE (count=2), rst pulsed low 1 clk -> no key_valid, key_col=001 immediately, key_held=0.
